hilo_unit: RTL and testbench
============================

# hilo_unit

HI/LO result register stage placed directly downstream of the 32x32 unsigned multiplier. It consumes the multiplier's 64-bit `dataOut` and models the iterative 32-step multiply timing with a cycle counter. When the count completes it latches the product into HI/LO, and it serves `MFHI`/`MFLO` reads to the register-file write-back path.

## Interface
Parameters:
- `WAIT_CYCLES`, 32: consecutive `MULTU` edges required before capture; legal range 1..63.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, synchronous, active-low.
- `signal`, in, 3: op code, shared with the multiplier.
- `prod`, in, 64: product, wired to the multiplier's `dataOut`.
- `hi`, out, 32: HI register.
- `lo`, out, 32: LO register.
- `dataOut`, out, 32: registered `MFHI`/`MFLO` read value.
- `busy`, out, 1: a multiply is in progress.
- `done`, out, 1: one-cycle pulse, HI/LO just updated.

## Operation
- Op codes:
  - `OP_NOP` = 3'b000
  - `OP_MULTU` = 3'b100 (the same value the multiplier decodes)
  - `OP_MFHI` = 3'b101
  - `OP_MFLO` = 3'b110
  - `OP_CLRHL` = 3'b111
  - All other codes behave as `OP_NOP`.
- IDLE state:
  - `OP_MULTU` → COUNT with `cnt`=1. If `WAIT_CYCLES`==1, capture immediately and stay in IDLE.
  - `OP_MFHI` → `dataOut`<=`hi`.
  - `OP_MFLO` → `dataOut`<=`lo`.
  - Other codes → hold state.
- COUNT state:
  - `signal`==`OP_MULTU` and `cnt`<`WAIT_CYCLES`-1 → `cnt`++.
  - `signal`==`OP_MULTU` and `cnt`==`WAIT_CYCLES`-1 → capture `prod`, go to IDLE, `cnt`=0.
  - Any other code → abort: go to IDLE, HI/LO unchanged, no `done`. A read code seen in COUNT is not executed.
- Capture: `{hi,lo}` <= `prod`, i.e. `hi`=`prod[63:32]` and `lo`=`prod[31:0]`. With `HILO_ACC_EN`, capture adds instead (see Configuration).
- `busy` = (state==COUNT), registered.
- `done` is registered, high only for the cycle after the capture edge.
- `dataOut` holds its value except on `MFHI`/`MFLO` edges in IDLE.

## Timing
- Reset (`rst`==0 at an edge) sets `hi`=0, `lo`=0, `dataOut`=0, `busy`=0, `done`=0, `cnt`=0, state=IDLE.
- Reset has priority over capture, read and abort on the same edge. Reset in mid-count discards the operation with no `done`.
- Capture timing: `signal`=`OP_MULTU` sampled on `WAIT_CYCLES` consecutive edges (E1..E`WAIT_CYCLES`). `prod` is sampled at edge E`WAIT_CYCLES`, and the new `hi`/`lo` are visible after that edge.
- `busy` is high from after E1 through E(`WAIT_CYCLES`-1) and low after E`WAIT_CYCLES`.
- `done` is high for exactly one cycle, after E`WAIT_CYCLES`.
- Back-to-back: `OP_MULTU` still present at E(`WAIT_CYCLES`+1) starts a new operation.
- Read latency: the `MFHI`/`MFLO` edge updates `dataOut` one cycle later.
- Read-after-multiply: a read sampled on the edge after capture returns the new value.
- `prod` must be stable at the capture edge. It is never registered early.

## Configuration
- `HILO_ACC_EN` defined:
  - Capture performs `{hi,lo}` <= `{hi,lo}` + `prod`, modulo 2^64; the carry out is discarded.
  - `OP_CLRHL` in IDLE zeroes `hi` and `lo` in one cycle, with no `done`.
- `HILO_ACC_EN` undefined:
  - Capture overwrites HI/LO.
  - `OP_CLRHL` behaves as `OP_NOP`.

## Structure
- Package `hilo_pkg` holds:
  - the `OP_*` localparams;
  - the state typedef (IDLE, COUNT);
  - the default `WAIT_CYCLES`.
- The multiplier adopts the same `OP_MULTU` constant from this package.
- Sub-module `hilo_seq_ctrl` contains the FSM and 6-bit counter and outputs `capture`, `busy` and `done`.
- The top level holds the HI/LO registers, the optional adder and the read mux.

## Test plan
- 7×6: `prod`=42, `OP_MULTU` for 32 edges → `lo`=42, `hi`=0, `done` high 1 cycle, `busy` low after. Then `OP_MFLO` → `dataOut`=42.
- 0xFFFFFFFF×0xFFFFFFFF: `prod`=0xFFFFFFFE00000001 → `hi`=0xFFFFFFFE, `lo`=0x00000001. Then `OP_MFHI` → `dataOut`=0xFFFFFFFE.
- Abort: after the first multiply, start 3×3 and switch to `OP_NOP` at E10 → `hi`/`lo` still 0/42, no `done`, `busy`=0.
- Reset mid-count: `rst`=0 at E20 → all outputs 0. A fresh 2×5 multiply then yields `lo`=10 after 32 edges.
- Back-to-back: `OP_MULTU` held 64 edges with `prod`=42 then 100 → `done` pulses after E32 and E64, final `lo`=100. With `HILO_ACC_EN` the final `lo`=142.
- `HILO_ACC_EN`: `OP_CLRHL` then two multiplies of `prod`=0xFFFFFFFF → `hi`=1, `lo`=0xFFFFFFFE. Without the macro → `hi`=0, `lo`=0xFFFFFFFF.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared op codes, FSM state constants and the default multiply latency for the
// HI/LO stage and the multiplier. No configuration macros live here.
package hilo_pkg;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b100;
  localparam logic [2:0] OP_MFHI  = 3'b101;
  localparam logic [2:0] OP_MFLO  = 3'b110;
  localparam logic [2:0] OP_CLRHL = 3'b111;

  localparam int HILO_WAIT_CYCLES = 32;

  typedef logic [0:0] hilo_state_t;
  localparam hilo_state_t ST_IDLE  = 1'b0;
  localparam hilo_state_t ST_COUNT = 1'b1;

  function automatic logic is_multu(input logic [2:0] op);
    return (op == OP_MULTU);
  endfunction

endpackage

// File: rtl/hilo_seq_ctrl.sv
// Multiply-timing sequencer: counts consecutive MULTU edges and flags the
// capture edge; any other op code in mid-count aborts the operation.
module hilo_seq_ctrl
  import hilo_pkg::*;
#(
  parameter int WAIT_CYCLES = HILO_WAIT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] signal,
  output logic       capture,
  output logic       idle,
  output logic       busy,
  output logic       done
);

  localparam logic [5:0] LAST_CNT = 6'(WAIT_CYCLES - 1);

  hilo_state_t state_r;
  hilo_state_t state_nxt_s;
  logic [5:0]  cnt_r;
  logic [5:0]  cnt_nxt_s;
  logic        capture_s;
  logic        busy_r;
  logic        done_r;

  // Next-state, counter and capture-edge decode
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    capture_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (is_multu(signal)) begin
          if (WAIT_CYCLES == 1) begin
            capture_s   = 1'b1;
            cnt_nxt_s   = 6'd0;
            state_nxt_s = ST_IDLE;
          end else begin
            cnt_nxt_s   = 6'd1;
            state_nxt_s = ST_COUNT;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (is_multu(signal)) begin
          if (cnt_r == LAST_CNT) begin
            capture_s   = 1'b1;
            cnt_nxt_s   = 6'd0;
            state_nxt_s = ST_IDLE;
          end else begin
            cnt_nxt_s   = cnt_r + 6'd1;
          end
        end else begin
          // abort: HI/LO untouched, no done
          cnt_nxt_s   = 6'd0;
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        cnt_nxt_s   = 6'd0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, counter and registered status flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 6'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      busy_r  <= (state_nxt_s == ST_COUNT);
      done_r  <= capture_s;
    end
  end

  assign capture = capture_s;
  assign idle    = (state_r == ST_IDLE);
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: rtl/hilo_unit.sv
// HI/LO result registers behind the 32x32 multiplier, with MFHI/MFLO read port.
// Define HILO_ACC_EN to make capture accumulate and to enable OP_CLRHL.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int WAIT_CYCLES = HILO_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  signal,
  input  logic [63:0] prod,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] dataOut,
  output logic        busy,
  output logic        done
);

  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic [31:0] data_r;
  logic [63:0] hilo_nxt_s;
  logic        capture_s;
  logic        idle_s;
  logic        clr_s;

  hilo_seq_ctrl #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_seq (
    .clk     (clk),
    .rst     (rst),
    .signal  (signal),
    .capture (capture_s),
    .idle    (idle_s),
    .busy    (busy),
    .done    (done)
  );

`ifdef HILO_ACC_EN
  assign hilo_nxt_s = {hi_r, lo_r} + prod;
  assign clr_s      = idle_s && (signal == OP_CLRHL);
`else
  assign hilo_nxt_s = prod;
  assign clr_s      = 1'b0;
`endif

  // HI/LO update: capture from the multiplier or clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (capture_s) begin
      hi_r <= hilo_nxt_s[63:32];
      lo_r <= hilo_nxt_s[31:0];
    end else if (clr_s) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else begin
      hi_r <= hi_r;
      lo_r <= lo_r;
    end
  end

  // Read port: reads only execute while no multiply is counting
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_r <= 32'd0;
    end else if (idle_s) begin
      case (signal)
        OP_MFHI: data_r <= hi_r;
        OP_MFLO: data_r <= lo_r;
        default: data_r <= data_r;
      endcase
    end else begin
      data_r <= data_r;
    end
  end

  assign hi      = hi_r;
  assign lo      = lo_r;
  assign dataOut = data_r;

endmodule

// File: tb/tb_hilo_unit.sv
// Bench for hilo_unit: directed scenarios then random op streams, all checked
// every cycle against a consecutive-edge-count reference model.
module tb_hilo_unit;

  localparam int         W      = 32;
  localparam logic [2:0] T_NOP  = 3'b000;
  localparam logic [2:0] T_MUL  = 3'b100;
  localparam logic [2:0] T_MFHI = 3'b101;
  localparam logic [2:0] T_MFLO = 3'b110;
  localparam logic [2:0] T_CLR  = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  signal;
  logic [63:0] prod;
  logic [31:0] hi, lo, dataOut;
  logic        busy, done;

  int checks = 0;
  int failures = 0;

  logic [63:0] m_hilo;
  logic [31:0] m_dout;
  int          m_run;
  logic        m_done;

  hilo_unit #(.WAIT_CYCLES(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .signal  (signal),
    .prod    (prod),
    .hi      (hi),
    .lo      (lo),
    .dataOut (dataOut),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_capture();
`ifdef HILO_ACC_EN
    m_hilo = m_hilo + prod;
`else
    m_hilo = prod;
`endif
    m_done = 1'b1;
  endtask

  // Reference: m_run is the number of consecutive MULTU edges in the current op
  task automatic model_edge();
    if (!rst) begin
      m_hilo = 64'd0; m_dout = 32'd0; m_run = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_run == 0) begin
        case (signal)
          T_MUL: begin
            m_run = 1;
            if (m_run == W) begin
              model_capture();
              m_run = 0;
            end
          end
          T_MFHI: m_dout = m_hilo[63:32];
          T_MFLO: m_dout = m_hilo[31:0];
`ifdef HILO_ACC_EN
          T_CLR:  m_hilo = 64'd0;
`endif
          default: ;
        endcase
      end else if (signal == T_MUL) begin
        m_run = m_run + 1;
        if (m_run == W) begin
          model_capture();
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic step(input logic r, input logic [2:0] s, input logic [63:0] p);
    rst = r; signal = s; prod = p;
    @(posedge clk);
    model_edge();
    #1;
    chk("hi", {32'd0, hi}, {32'd0, m_hilo[63:32]});
    chk("lo", {32'd0, lo}, {32'd0, m_hilo[31:0]});
    chk("dataOut", {32'd0, dataOut}, {32'd0, m_dout});
    chk("busy", {63'd0, busy}, {63'd0, (m_run != 0)});
    chk("done", {63'd0, done}, {63'd0, m_done});
  endtask

  task automatic mult(input logic [63:0] p, input int n);
    for (int i = 0; i < n; i++) step(1'b1, T_MUL, p);
  endtask

  initial begin
    logic [2:0]  op;
    logic [63:0] exp_v;

    // reset
    step(1'b0, T_NOP, 64'd0);
    step(1'b0, T_NOP, 64'd0);
    chk("reset_state", {hi, lo}, 64'd0);
    chk("reset_dout", {32'd0, dataOut}, 64'd0);

    // 7x6
    mult(64'd42, W - 1);
    chk("busy_mid", {63'd0, busy}, 64'd1);
    mult(64'd42, 1);
    chk("mul1_lo", {32'd0, lo}, 64'd42);
    chk("mul1_hi", {32'd0, hi}, 64'd0);
    chk("mul1_done", {63'd0, done}, 64'd1);
    chk("mul1_busy", {63'd0, busy}, 64'd0);
    step(1'b1, T_MFLO, 64'd0);
    chk("mul1_done_drop", {63'd0, done}, 64'd0);
    chk("mflo", {32'd0, dataOut}, 64'd42);

    // abort 3x3 at E10 with a read that must not execute
    mult(64'd9, 9);
    step(1'b1, T_MFHI, 64'd9);
    chk("abort_hilo", {hi, lo}, 64'd42);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_noread", {32'd0, dataOut}, 64'd42);

    // max x max
    mult(64'hFFFF_FFFE_0000_0001, W);
`ifdef HILO_ACC_EN
    exp_v = 64'hFFFF_FFFE_0000_002B;
`else
    exp_v = 64'hFFFF_FFFE_0000_0001;
`endif
    chk("max_hilo", {hi, lo}, exp_v);
    step(1'b1, T_MFHI, 64'd0);
    chk("mfhi_after_mul", {32'd0, dataOut}, {32'd0, exp_v[63:32]});

    // reset mid-count, then 2x5
    mult(64'd77, 19);
    step(1'b0, T_MUL, 64'd77);
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    chk("rst_mid_flags", {62'd0, busy, done}, 64'd0);
    mult(64'd10, W);
    chk("fresh_lo", {32'd0, lo}, 64'd10);

    // back-to-back from a clean state
    step(1'b0, T_NOP, 64'd0);
    mult(64'd42, W);
    chk("b2b_done1", {63'd0, done}, 64'd1);
    mult(64'd100, W);
    chk("b2b_done2", {63'd0, done}, 64'd1);
`ifdef HILO_ACC_EN
    chk("b2b_lo", {32'd0, lo}, 64'd142);
`else
    chk("b2b_lo", {32'd0, lo}, 64'd100);
`endif

    // CLRHL then two multiplies of 0xFFFFFFFF
    step(1'b1, T_CLR, 64'd0);
    mult(64'h0000_0000_FFFF_FFFF, W);
    step(1'b1, T_NOP, 64'd0);
    mult(64'h0000_0000_FFFF_FFFF, W);
`ifdef HILO_ACC_EN
    chk("clr_acc", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
`else
    chk("clr_acc", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
`endif

    // random op streams
    for (int seg = 0; seg < 60; seg++) begin
      for (int k = 0; k < int'($urandom_range(1, 40)); k++)
        step(1'b1, T_MUL, {$urandom, $urandom});
      op = 3'($urandom_range(0, 7));
      step(($urandom_range(0, 29) != 0), op, {$urandom, $urandom});
      if ($urandom_range(0, 2) == 0) step(1'b1, T_MFHI, 64'd0);
      if ($urandom_range(0, 2) == 0) step(1'b1, T_MFLO, 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
